mil_bc_msg_seq: RTL and testbench

MIL-STD-1553 bus-controller message sequencer. It accepts a start pulse and a command word (CW), then drives the word-level Manchester transmitter one word at a time: the CW first, then the data words (DW) fetched from a data source. It holds the transmit-enable window open for the whole message, then waits a bounded time for the remote terminal's status word. It sits between the host-side message setup and the transmit encoder, replacing a fixed-length txen window with handshake-driven sequencing.

---
 rtl/mil_bc_msg_seq_if.sv | 27 ++
 rtl/mil_bc_msg_seq.sv | 93 +++++++++
 tb/tb_mil_bc_msg_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mil_bc_msg_seq_if.sv
// mil_bc_msg_seq_if: host/encoder/data-source signals of the 1553 BC message sequencer
interface mil_bc_msg_seq_if;
    logic        st;
    logic [15:0] cw;
    logic        dw_req;
    logic [15:0] dw;
    logic        dw_vld;
    logic [15:0] tx_word;
    logic        tx_csync;
    logic        tx_ld;
    logic        tx_done;
    logic        txen;
    logic        busy;
    logic        rsp_vld;
    logic [15:0] rsp_word;
    logic [15:0] sts;
    logic        msg_ok;
    logic        msg_tmo;
    modport slave (
        input  st, cw, dw, dw_vld, tx_done, rsp_vld, rsp_word,
        output dw_req, tx_word, tx_csync, tx_ld, txen, busy, sts, msg_ok, msg_tmo
    );
    modport master (
        output st, cw, dw, dw_vld, tx_done, rsp_vld, rsp_word,
        input  dw_req, tx_word, tx_csync, tx_ld, txen, busy, sts, msg_ok, msg_tmo
    );
endinterface

// File: rtl/mil_bc_msg_seq.sv
// mil_bc_msg_seq: sequences CW then DWs into the encoder, then waits for the RT status word
module mil_bc_msg_seq #(
    parameter int RSP_TMO = 700
) (
    input logic            clk,
    input logic            rst_n,
    mil_bc_msg_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SEND_CW, FETCH, SEND_DW, WAIT_RSP} state_t;
    localparam logic [11:0] TMO_LAST = 12'(RSP_TMO - 1);
    state_t      state;
    logic        tr;
    logic [5:0]  nw;
    logic [5:0]  remaining;
    logic [11:0] timer;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tr           <= 1'b0;
            nw           <= 6'd0;
            remaining    <= 6'd0;
            timer        <= 12'd0;
            bus.tx_word  <= 16'd0;
            bus.tx_csync <= 1'b0;
            bus.tx_ld    <= 1'b0;
            bus.dw_req   <= 1'b0;
            bus.txen     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.sts      <= 16'd0;
            bus.msg_ok   <= 1'b0;
            bus.msg_tmo  <= 1'b0;
        end else begin
            bus.tx_ld   <= 1'b0;
            bus.dw_req  <= 1'b0;
            bus.msg_ok  <= 1'b0;
            bus.msg_tmo <= 1'b0;
            case (state)
                IDLE: if (bus.st) begin
                    tr           <= bus.cw[10];
                    nw           <= bus.cw[4:0] == 5'd0 ? 6'd32 : {1'b0, bus.cw[4:0]};
                    bus.tx_word  <= bus.cw;
                    bus.tx_csync <= 1'b1;
                    bus.tx_ld    <= 1'b1;
                    bus.txen     <= 1'b1;
                    bus.busy     <= 1'b1;
                    state        <= SEND_CW;
                end
                SEND_CW: if (bus.tx_done) begin
                    if (tr) begin
                        bus.txen <= 1'b0;
                        timer    <= 12'd0;
                        state    <= WAIT_RSP;
                    end else begin
                        bus.dw_req <= 1'b1;
                        remaining  <= nw;
                        state      <= FETCH;
                    end
                end
                FETCH: if (bus.dw_vld) begin
                    bus.tx_word  <= bus.dw;
                    bus.tx_csync <= 1'b0;
                    bus.tx_ld    <= 1'b1;
                    state        <= SEND_DW;
                end
                SEND_DW: if (bus.tx_done) begin
                    remaining <= remaining - 6'd1;
                    if (remaining == 6'd1) begin
                        bus.txen <= 1'b0;
                        timer    <= 12'd0;
                        state    <= WAIT_RSP;
                    end else begin
                        bus.dw_req <= 1'b1;
                        state      <= FETCH;
                    end
                end
                WAIT_RSP: begin
                    timer <= timer + 12'd1;
                    if (bus.rsp_vld) begin
                        bus.sts    <= bus.rsp_word;
                        bus.msg_ok <= 1'b1;
                        bus.busy   <= 1'b0;
                        state      <= IDLE;
                    end else if (timer == TMO_LAST) begin
                        bus.msg_tmo <= 1'b1;
                        bus.busy    <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mil_bc_msg_seq.sv
// tb_mil_bc_msg_seq: acts as host, data source, encoder and remote terminal around the sequencer
module tb_mil_bc_msg_seq;
    localparam int RSP_TMO = 700;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int nreq = 0;
    logic [16:0] q_tx[$];
    logic [15:0] preset[$];
    logic [15:0] exp_sts = 16'd0;
    mil_bc_msg_seq_if bus();
    mil_bc_msg_seq #(.RSP_TMO(RSP_TMO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // Encoder-side view: every loaded word and every data request, as the outside world sees them
    always @(negedge clk) if (rst_n) begin
        if (bus.tx_ld) q_tx.push_back({bus.tx_csync, bus.tx_word});
        if (bus.dw_req) nreq++;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic chk_quiet(input string tag);
        chk({tag, "_txen"}, bus.txen, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_ld"}, bus.tx_ld, 0);
        chk({tag, "_req"}, bus.dw_req, 0);
        chk({tag, "_ok"}, bus.msg_ok, 0);
        chk({tag, "_tmo"}, bus.msg_tmo, 0);
        chk({tag, "_sts"}, bus.sts, exp_sts);
    endtask
    // rsp_at: cycles after the final tx_done edge at which the RT answers; 0 = never
    task automatic send_msg(input logic [15:0] c, input int dly, input int stall, input int rsp_at, input bit stray);
        int n, k, txen_low, early;
        logic [15:0] words[$];
        logic [15:0] r;
        n = c[10] ? 0 : (c[4:0] == 5'd0 ? 32 : int'(c[4:0]));
        q_tx.delete();
        nreq = 0;
        txen_low = 0;
        early = 0;
        bus.cw = c;
        bus.st = 1'b1;
        @(negedge clk);
        bus.st = 1'b0;
        bus.cw = 16'($urandom);
        chk("st_ld", bus.tx_ld, 1);
        chk("st_txen", bus.txen, 1);
        chk("st_busy", bus.busy, 1);
        for (int w = 0; w <= n; w++) begin
            for (int d = 0; d < dly; d++) begin
                bus.st = stray && w == 1 && d == 0;
                @(negedge clk);
                bus.st = 1'b0;
                if (!bus.txen) txen_low++;
            end
            bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
            if (w == n) break;
            chk("dw_req", bus.dw_req, 1);
            for (int d = 0; d < stall; d++) begin
                @(negedge clk);
                if (!bus.txen) txen_low++;
            end
            r = preset.size() != 0 ? preset.pop_front() : 16'($urandom);
            words.push_back(r);
            bus.dw = r;
            bus.dw_vld = 1'b1;
            @(negedge clk);
            bus.dw_vld = 1'b0;
            if (!bus.txen) txen_low++;
            chk("dw_ld", bus.tx_ld, 1);
        end
        chk("txen_hold", txen_low, 0);
        chk("txen_off", bus.txen, 0);
        chk("n_ld", q_tx.size(), n + 1);
        chk("n_req", nreq, n);
        for (int i = 0; i < q_tx.size() && i <= n; i++) begin
            if (i == 0) chk("cw_word", q_tx[i], {1'b1, c});
            else chk("dw_word", q_tx[i], {1'b0, words[i-1]});
        end
        if (rsp_at > 0) begin
            for (int d = 1; d < rsp_at; d++) begin
                @(negedge clk);
                if (bus.msg_ok || bus.msg_tmo || !bus.busy) early++;
            end
            r = preset.size() != 0 ? preset.pop_front() : 16'($urandom);
            bus.rsp_word = r;
            bus.rsp_vld = 1'b1;
            @(negedge clk);
            bus.rsp_vld = 1'b0;
            exp_sts = r;
            chk("rsp_early", early, 0);
            chk("rsp_ok", bus.msg_ok, 1);
            chk("rsp_no_tmo", bus.msg_tmo, 0);
        end else begin
            k = 0;
            while (!bus.msg_tmo && !bus.msg_ok && k < 2 * RSP_TMO) begin
                @(negedge clk);
                k++;
            end
            chk("tmo_lat", k, RSP_TMO);
            chk("tmo_pulse", bus.msg_tmo, 1);
            chk("tmo_no_ok", bus.msg_ok, 0);
        end
        chk("end_busy", bus.busy, 0);
        chk("end_sts", bus.sts, exp_sts);
        @(negedge clk);
        chk("end_pulse_clr", {bus.msg_ok, bus.msg_tmo}, 0);
    endtask
    initial begin
        logic [15:0] c;
        bus.st = 0; bus.cw = 0; bus.dw = 0; bus.dw_vld = 0;
        bus.tx_done = 0; bus.rsp_vld = 0; bus.rsp_word = 0;
        repeat (3) @(negedge clk);
        chk("rst_word", bus.tx_word, 0);
        chk("rst_csync", bus.tx_csync, 0);
        chk_quiet("rst");
        rst_n = 1'b1;
        @(negedge clk);
        preset = '{16'h2233, 16'h4455, 16'h0800};
        send_msg(16'h0822, 1000, 0, 37, 0);
        chk("t1_sts", exp_sts, 16'h0800);
        send_msg(16'h0C25, 4, 0, 5, 0);
        send_msg(16'h1000, 3, 0, 2, 0);
        send_msg(16'h0803, 5, 1, 0, 0);
        send_msg(16'h0802, 5, 0, RSP_TMO, 0);
        send_msg(16'h0C00, 3, 0, 1, 0);
        send_msg(16'h0803, 4, 2, 9, 1);
        q_tx.delete();
        bus.tx_done = 1'b1; bus.dw_vld = 1'b1; bus.rsp_vld = 1'b1; bus.rsp_word = 16'hFFFF;
        @(negedge clk);
        bus.tx_done = 1'b0; bus.dw_vld = 1'b0; bus.rsp_vld = 1'b0;
        chk_quiet("stray");
        @(negedge clk);
        chk_quiet("stray2");
        chk("stray_nld", q_tx.size(), 0);
        send_msg(16'h0801, 2, 5000, 3, 0);
        for (int i = 0; i < 5; i++) begin
            c = 16'($urandom);
            send_msg(c, $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 1) != 0 ? $urandom_range(1, RSP_TMO) : 0, 0);
        end
        bus.cw = 16'h0823;
        bus.st = 1'b1;
        @(negedge clk);
        bus.st = 1'b0;
        for (int w = 0; w < 2; w++) begin
            repeat (3) @(negedge clk);
            bus.tx_done = 1'b1;
            @(negedge clk);
            bus.tx_done = 1'b0;
            bus.dw = 16'($urandom);
            bus.dw_vld = 1'b1;
            @(negedge clk);
            bus.dw_vld = 1'b0;
        end
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_sts = 16'd0;
        chk("mid_word", bus.tx_word, 0);
        chk("mid_csync", bus.tx_csync, 0);
        chk_quiet("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_quiet("post_rst");
        send_msg(16'h0822, 2, 0, 4, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
